ex_div_ctrl: RTL

EX-stage sequencer for the multi-cycle divider (`div`). It accepts a DIV/DIVU instruction from the EX stage and latches its operands. It drives the divider's start/annul/signed handshake and holds operands stable for the whole operation, raising a stall request to the pipeline controller until the quotient and remainder are available. It then presents HI/LO write data to MEM/WB, handling flushes and downstream stalls without re-triggering or corrupting the divider.

---
 rtl/ex_div_ctrl_pkg.sv | 23 ++
 rtl/ex_div_ctrl.sv | 134 +++++++++++++
 2 files changed

// File: rtl/ex_div_ctrl_pkg.sv
// Shared encodings for the EX-stage divider sequencer: FSM states, handshake levels
// and bus widths used between the controller and the multi-cycle divider.
package ex_div_ctrl_pkg;

    localparam logic [1:0] StIdle  = 2'b00;
    localparam logic [1:0] StBusy  = 2'b01;
    localparam logic [1:0] StDone  = 2'b10;
    localparam logic [1:0] StDrain = 2'b11;

    localparam logic DivStart = 1'b1;
    localparam logic DivStop  = 1'b0;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    localparam logic RstEnable = 1'b1;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    localparam int unsigned DoubleRegBusW = 64;
    typedef logic [DoubleRegBusW-1:0] double_reg_bus_t;

endpackage

// File: rtl/ex_div_ctrl.sv
// EX-stage sequencer for the multi-cycle divider: latches operands, drives the divider
// handshake, stalls the pipeline while busy and presents HI/LO write data.
module ex_div_ctrl
    import ex_div_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            div_req_i,
    input  logic            div_signed_i,
    input  logic [31:0]     op1_i,
    input  logic [31:0]     op2_i,
    input  logic            flush_i,
    input  logic            stall_i,
    input  double_reg_bus_t div_result_i,
    input  logic            div_ready_i,
    output logic            div_start_o,
    output logic            div_annul_o,
    output logic            div_signed_o,
    output logic [31:0]     div_opdata1_o,
    output logic [31:0]     div_opdata2_o,
    output logic            stallreq_o,
    output logic            whilo_o,
    output logic [31:0]     hi_o,
    output logic [31:0]     lo_o
);

    localparam int unsigned CntW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            signed_q, signed_d;
    logic [31:0]     op1_q, op1_d;
    logic [31:0]     op2_q, op2_d;
    double_reg_bus_t res_q, res_d;

    logic ready;
    assign ready = (div_ready_i == DivResultReady);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        signed_d      = signed_q;
        op1_d         = op1_q;
        op2_d         = op2_q;
        res_d         = res_q;
        div_start_o   = DivStop;
        div_annul_o   = 1'b0;
        div_signed_o  = 1'b0;
        div_opdata1_o = ZeroWord;
        div_opdata2_o = ZeroWord;
        stallreq_o    = 1'b0;
        whilo_o       = 1'b0;
        hi_o          = ZeroWord;
        lo_o          = ZeroWord;

        unique case (state_q)
            // div_ready_i may still be high from the previous operation here; ignore it.
            StIdle: begin
                stallreq_o = div_req_i & ~flush_i;
                if (div_req_i && !flush_i) begin
                    signed_d = div_signed_i;
                    op1_d    = op1_i;
                    op2_d    = op2_i;
                    state_d  = StBusy;
                end
            end
            StBusy: begin
                div_start_o   = DivStart;
                div_signed_o  = signed_q;
                div_opdata1_o = op1_q;
                div_opdata2_o = op2_q;
                stallreq_o    = ~ready & ~flush_i;
                if (flush_i) begin
                    div_annul_o = 1'b1;
                    cnt_d       = CntW'(DRAIN_CYCLES);
                    state_d     = StDrain;
                end else if (ready) begin
                    whilo_o = 1'b1;
                    hi_o    = div_result_i[63:32];
                    lo_o    = div_result_i[31:0];
                    res_d   = div_result_i;
                    state_d = stall_i ? StDone : StIdle;
                end
            end
            // Keep start high so the divider parks in its end state while EX is held.
            StDone: begin
                div_start_o   = DivStart;
                div_signed_o  = signed_q;
                div_opdata1_o = op1_q;
                div_opdata2_o = op2_q;
                if (!flush_i) begin
                    whilo_o = 1'b1;
                    hi_o    = res_q[63:32];
                    lo_o    = res_q[31:0];
                end
                if (!stall_i || flush_i) begin
                    state_d = StIdle;
                end
            end
            // Start held low long enough to release the divider from states annul cannot exit.
            StDrain: begin
                stallreq_o = div_req_i;
                cnt_d      = cnt_q - CntW'(1);
                if (cnt_q <= CntW'(1)) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            signed_q <= 1'b0;
            op1_q    <= ZeroWord;
            op2_q    <= ZeroWord;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            signed_q <= signed_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            res_q    <= res_d;
        end
    end

endmodule
